// File: rtl/ara_eoc_pkg.sv
// ara_eoc_pkg: shared state encoding, exit codes and exit-word helper for the EOC controller.
package ara_eoc_pkg;
  typedef enum logic [1:0] {HOLD, RUN, SERVICE, DONE} eoc_state_e;
  localparam logic [62:0] EocTimeout = 63'd1;
  localparam logic [62:0] EocOverrun = 63'd2;
  function automatic logic [63:0] eoc_exit_word(input logic [62:0] code);
    return {code, 1'b1};
  endfunction
endpackage

// File: rtl/ara_eoc_watchdog.sv
// ara_eoc_watchdog: saturating cycle counter with enable, clear and limit-match flag.
module ara_eoc_watchdog #(
  parameter int W = 64
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  input  logic         clr_i,
  input  logic [W-1:0] limit_i,
  output logic [W-1:0] count_o,
  output logic         match_o
);
  logic [W-1:0] r_count;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_count <= '0;
    else if (clr_i) r_count <= '0;
    else if (en_i && !(&r_count)) r_count <= r_count + 1'b1;
  end
  assign count_o = r_count;
  assign match_o = r_count == limit_i;
endmodule

// File: rtl/ara_eoc_controller.sv
// ara_eoc_controller: core reset sequencing, tohost mailbox snooping, host request channel
// and exit-word generation with watchdog and mailbox-overrun detection.
module ara_eoc_controller
  import ara_eoc_pkg::*;
#(
  parameter int                   AddrWidth       = 64,
  parameter logic [AddrWidth-1:0] ToHostAddr      = AddrWidth'(64'h8000_1000),
  parameter int unsigned          ResetHoldCycles = 16,
  parameter int unsigned          TimeoutCycles   = 0,
  parameter int                   CntWidth        = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 snoop_valid_i,
  input  logic [AddrWidth-1:0] snoop_addr_i,
  input  logic [63:0]          snoop_data_i,
  input  logic [7:0]           snoop_be_i,
  output logic                 host_req_valid_o,
  output logic [63:0]          host_req_data_o,
  input  logic                 host_req_ready_i,
  output logic                 core_rst_no,
  output logic [63:0]          exit_o,
  output logic                 done_o,
  output logic [CntWidth-1:0]  cycles_o
);
  localparam int HW = $clog2(ResetHoldCycles) + 1;
  eoc_state_e    r_state;
  logic [63:0]   r_exit, r_req_data;
  logic          r_req_valid, r_core_rst_n;
  logic          w_hit, w_hold_match, w_wd_match, w_wd_fire, w_counting;
  logic [HW-1:0] w_unused_hold_cnt;
  assign w_hit      = snoop_valid_i && snoop_addr_i == ToHostAddr && snoop_be_i == 8'hFF;
  assign w_counting = r_state == RUN || r_state == SERVICE;
  assign w_wd_fire  = TimeoutCycles != 0 && w_wd_match;
  ara_eoc_watchdog #(.W(HW)) u_hold (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .en_i    (r_state == HOLD),
    .clr_i   (r_state != HOLD),
    .limit_i (HW'(ResetHoldCycles - 1)),
    .count_o (w_unused_hold_cnt),
    .match_o (w_hold_match)
  );
  ara_eoc_watchdog #(.W(CntWidth)) u_cycles (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .en_i    (w_counting),
    .clr_i   (r_state == HOLD),
    .limit_i (CntWidth'(TimeoutCycles - 1)),
    .count_o (cycles_o),
    .match_o (w_wd_match)
  );
  // A mailbox hit always takes priority over the watchdog firing in the same cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state      <= HOLD;
      r_exit       <= '0;
      r_req_data   <= '0;
      r_req_valid  <= 1'b0;
      r_core_rst_n <= 1'b0;
    end else begin
      case (r_state)
        HOLD: if (w_hold_match) begin
          r_state      <= RUN;
          r_core_rst_n <= 1'b1;
        end
        RUN: if (w_hit && snoop_data_i[0]) begin
          r_exit  <= snoop_data_i;
          r_state <= DONE;
        end else if (w_hit) begin
          r_req_valid <= 1'b1;
          r_req_data  <= snoop_data_i;
          r_state     <= SERVICE;
        end else if (w_wd_fire) begin
          r_exit  <= eoc_exit_word(EocTimeout);
          r_state <= DONE;
        end
        SERVICE: if (w_hit) begin
          r_exit      <= eoc_exit_word(EocOverrun);
          r_req_valid <= 1'b0;
          r_state     <= DONE;
        end else if (w_wd_fire) begin
          r_exit      <= eoc_exit_word(EocTimeout);
          r_req_valid <= 1'b0;
          r_state     <= DONE;
        end else if (host_req_ready_i) begin
          r_req_valid <= 1'b0;
          r_state     <= RUN;
        end
        default: ;
      endcase
    end
  end
  assign host_req_valid_o = r_req_valid;
  assign host_req_data_o  = r_req_data;
  assign core_rst_no      = r_core_rst_n;
  assign exit_o           = r_exit;
  assign done_o           = r_exit[0];
endmodule
